// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared definitions for the RAM access controller: default RAM geometry and
// the controller state encoding.
package ram_ctrl_pkg;

   localparam int ADDR_W_DEFAULT = 5;   // 32-word RAM
   localparam int DATA_W_DEFAULT = 3;   // 3-bit words

   typedef enum logic [2:0] {
      CLEAR   = 3'd0,   // zero-fill the whole RAM after reset
      IDLE    = 3'd1,   // accept writes, wait for the next scan tick
      WRITE   = 3'd2,   // single RAM write cycle
      ISSUE   = 3'd3,   // present read address; RAM registers it
      CAPTURE = 3'd4    // RAM q valid; latch into the display registers
   } state_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if
// Write-request handshake between a user write source and ram_access_ctrl.
//   wr_req    source -> ctrl  request valid; held until wr_ready is seen
//   wr_addr   source -> ctrl  target address
//   wr_data   source -> ctrl  word to write
//   wr_ready  ctrl -> source  high only while the controller is idle
// Modports: master = write source, slave = controller.
interface ram_access_ctrl_if
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
);

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;

   modport master (output wr_req, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/ram_access_ctrl_scan_tick_gen.sv
// scan_tick_gen
// Free-running divider that produces a one-cycle scan tick every SCAN_DIV
// enabled cycles. The count only advances while en is high and is returned
// to zero by reset, by clr, or by its own tick.
//   clock  in   clock
//   reset  in   synchronous active-high reset
//   en     in   count enable (controller idle)
//   clr    in   synchronous counter clear
//   tick   out  high in the enabled cycle where the count reaches SCAN_DIV-1
module scan_tick_gen
   import ram_ctrl_pkg::*;
#(
   parameter int SCAN_DIV = 50_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] div_cnt_reg;

   assign tick = en & (div_cnt_reg == CNT_LAST);

   always_ff @(posedge clock) begin
      if (reset || clr || tick) begin
         div_cnt_reg <= '0;
      end else if (en) begin
         div_cnt_reg <= div_cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
// Upstream controller for a single-port RAM with registered read address.
// After reset it zero-fills every word, then serves user writes and, while
// idle, periodically reads one address at a time for a display.
//   clock        in   clock
//   reset        in   synchronous active-high reset
//   wr_bus       slave side of the write handshake (wr_req/addr/data/ready)
//   busy         out  high during reset and while clearing
//   mem_address  out  RAM address
//   mem_data     out  RAM write data
//   mem_wren     out  RAM write enable
//   mem_q        in   RAM read data (valid the cycle after the address)
//   disp_addr    out  address of the last completed read
//   disp_data    out  data of the last completed read
//   disp_valid   out  one-cycle pulse when disp_addr/disp_data update
module ram_access_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEFAULT,
   parameter int DATA_W   = DATA_W_DEFAULT,
   parameter int SCAN_DIV = 50_000_000
) (
   input  logic              clock,
   input  logic              reset,
   ram_access_ctrl_if.slave  wr_bus,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q,
   output logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state_reg;
   logic [ADDR_W-1:0] clr_cnt_reg;
   logic [ADDR_W-1:0] scan_ptr_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [DATA_W-1:0] wr_data_reg;
   logic [ADDR_W-1:0] disp_addr_reg;
   logic [DATA_W-1:0] disp_data_reg;
   logic              disp_valid_reg;

   logic is_idle;
   logic wr_accept;
   logic scan_tick;

   assign is_idle   = (state_reg == IDLE);
   assign wr_accept = is_idle & wr_bus.wr_req;

   // Accepting a write restarts the scan interval, so a tick landing in the
   // same cycle is simply lost.
   scan_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan_tick_gen (
      .clock (clock),
      .reset (reset),
      .en    (is_idle),
      .clr   (wr_accept),
      .tick  (scan_tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= CLEAR;
         clr_cnt_reg    <= '0;
         scan_ptr_reg   <= '0;
         wr_addr_reg    <= '0;
         wr_data_reg    <= '0;
         disp_addr_reg  <= '0;
         disp_data_reg  <= '0;
         disp_valid_reg <= 1'b0;
      end else begin
         disp_valid_reg <= 1'b0;
         case (state_reg)
            CLEAR: begin
               clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
               if (clr_cnt_reg == LAST_ADDR) begin
                  state_reg <= IDLE;
               end
            end
            IDLE: begin
               if (wr_bus.wr_req) begin
                  wr_addr_reg <= wr_bus.wr_addr;
                  wr_data_reg <= wr_bus.wr_data;
                  state_reg   <= WRITE;
               end else if (scan_tick) begin
                  // Pre-increment: the first read after clearing is address 1.
                  scan_ptr_reg <= scan_ptr_reg + ADDR_W'(1);
                  state_reg    <= ISSUE;
               end
            end
            WRITE: begin
               // Read the freshly written word back for the display.
               scan_ptr_reg <= wr_addr_reg;
               state_reg    <= ISSUE;
            end
            ISSUE: begin
               state_reg <= CAPTURE;
            end
            CAPTURE: begin
               disp_addr_reg  <= scan_ptr_reg;
               disp_data_reg  <= mem_q;
               disp_valid_reg <= 1'b1;
               state_reg      <= IDLE;
            end
            default: begin
               state_reg   <= CLEAR;
               clr_cnt_reg <= '0;
            end
         endcase
      end
   end

   // RAM-side outputs decode registered state only; reset gates the write
   // enable so a write cycle interrupted by reset never reaches the RAM.
   always_comb begin
      mem_wren    = 1'b0;
      mem_address = scan_ptr_reg;
      mem_data    = '0;
      case (state_reg)
         CLEAR: begin
            mem_wren    = 1'b1;
            mem_address = clr_cnt_reg;
         end
         WRITE: begin
            mem_wren    = 1'b1;
            mem_address = wr_addr_reg;
            mem_data    = wr_data_reg;
         end
         default: ;
      endcase
      if (reset) begin
         mem_wren = 1'b0;
      end
   end

   assign busy            = reset | (state_reg == CLEAR);
   assign wr_bus.wr_ready = ~reset & is_idle;
   assign disp_addr       = disp_addr_reg;
   assign disp_data       = disp_data_reg;
   assign disp_valid      = disp_valid_reg;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl
// Directed bench: ram_access_ctrl in front of a behavioural 32x3 single-port
// RAM with registered read address. SCAN_DIV is 8.
module tb_ram_access_ctrl;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 3;
   localparam int SCAN_DIV = 8;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   ram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_bus ();

   logic              busy;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data;
   logic              mem_wren;
   logic [DATA_W-1:0] mem_q;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;

   ram_access_ctrl #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .wr_bus      (wr_bus),
      .busy        (busy),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_wren    (mem_wren),
      .mem_q       (mem_q),
      .disp_addr   (disp_addr),
      .disp_data   (disp_data),
      .disp_valid  (disp_valid)
   );

   // 32x3 RAM, registered read address.
   logic [DATA_W-1:0] ram [0:31];
   logic [ADDR_W-1:0] ram_addr_reg;

   always @(posedge clock) begin
      if (mem_wren) ram[mem_address] <= mem_data;
      ram_addr_reg <= mem_address;
   end
   assign mem_q = ram[ram_addr_reg];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Hold reset for the given number of edges, checking the outputs it forces.
   task automatic apply_reset(input int cycles);
      reset = 1'b1;
      #1;
      check("rst_wren", mem_wren, 0);
      check("rst_busy", busy, 1);
      repeat (cycles) begin
         @(negedge clock); #1;
         check("rst_wren", mem_wren, 0);
         check("rst_busy", busy, 1);
         check("rst_ready", wr_bus.wr_ready, 0);
      end
      check("rst_disp_valid", disp_valid, 0);
      check("rst_disp_addr", disp_addr, 0);
      check("rst_disp_data", disp_data, 0);
      reset = 1'b0;
      #1;
      $display("reset released after %0d cycles", cycles);
   endtask

   // Called in the first CLEAR cycle; returns in the first IDLE cycle.
   task automatic run_clear();
      for (int i = 0; i < 32; i++) begin
         check("clr_busy", busy, 1);
         check("clr_wren", mem_wren, 1);
         check("clr_addr", mem_address, i);
         check("clr_data", mem_data, 0);
         check("clr_ready", wr_bus.wr_ready, 0);
         @(negedge clock); #1;
      end
      check("clr_done_ready", wr_bus.wr_ready, 1);
      check("clr_done_busy", busy, 0);
      check("clr_done_wren", mem_wren, 0);
      $display("clear complete");
   endtask

   // Wait for a display pulse, then check its contents, latency and width.
   task automatic wait_disp(input string tag, input int exp_addr, input int exp_data, input int exp_n);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clock); #1;
         n++;
         if (disp_valid) seen = 1'b1;
      end
      check({tag, "_seen"}, seen, 1);
      if (seen) begin
         $display("disp addr=%0d data=%0d after %0d cycles", disp_addr, disp_data, n);
         check({tag, "_addr"}, disp_addr, exp_addr);
         check({tag, "_data"}, disp_data, exp_data);
         check({tag, "_latency"}, n, exp_n);
         @(negedge clock); #1;
         check({tag, "_pulse"}, disp_valid, 0);
      end
   endtask

   // Issue a write from IDLE and follow it through to its display.
   task automatic do_write(input int addr, input int data);
      check("wr_ready_pre", wr_bus.wr_ready, 1);
      wr_bus.wr_req  = 1'b1;
      wr_bus.wr_addr = ADDR_W'(addr);
      wr_bus.wr_data = DATA_W'(data);
      @(negedge clock); #1;
      wr_bus.wr_req = 1'b0;
      $display("write addr=%0d data=%0d", addr, data);
      check("wr_wren", mem_wren, 1);
      check("wr_addr", mem_address, addr);
      check("wr_data", mem_data, data);
      check("wr_ready_write", wr_bus.wr_ready, 0);
      @(negedge clock); #1;
      check("wr_ready_issue", wr_bus.wr_ready, 0);
      check("wr_issue_wren", mem_wren, 0);
      check("wr_issue_addr", mem_address, addr);
      @(negedge clock); #1;
      check("wr_ready_capture", wr_bus.wr_ready, 0);
      wait_disp("wr_disp", addr, data, 1);
   endtask

   initial begin
      reset          = 1'b1;
      wr_bus.wr_req  = 1'b0;
      wr_bus.wr_addr = '0;
      wr_bus.wr_data = '0;

      // Power-up reset and full clear.
      apply_reset(2);
      run_clear();

      // Scan: first read is address 1, then 33 ticks wrap back to 1.
      wait_disp("scan_first", 1, 0, 10);
      for (int k = 2; k <= 33; k++) begin
         wait_disp("scan", k % 32, 0, 9);
      end

      // Plain write with read-back.
      do_write(5, 5);

      // Write in the same cycle as a scan tick: write wins, tick dropped.
      repeat (6) @(negedge clock);
      #1;
      do_write(9, 3);
      wait_disp("after_collision", 10, 0, 9);

      // Write the top address, then scan across the wrap.
      do_write(31, 7);
      wait_disp("wrap_0", 0, 0, 9);
      wait_disp("wrap_1", 1, 0, 9);

      // Reset in the middle of a clear.
      apply_reset(2);
      for (int i = 0; i < 17; i++) begin
         check("part_clr_addr", mem_address, i);
         @(negedge clock); #1;
      end
      check("part_clr_at17_addr", mem_address, 17);
      check("part_clr_at17_wren", mem_wren, 1);
      apply_reset(2);
      run_clear();

      // Reset during the WRITE cycle: the write must not reach the RAM.
      check("wr_rst_ready", wr_bus.wr_ready, 1);
      wr_bus.wr_req  = 1'b1;
      wr_bus.wr_addr = ADDR_W'(12);
      wr_bus.wr_data = DATA_W'(6);
      @(negedge clock); #1;
      wr_bus.wr_req = 1'b0;
      check("wr_rst_write_wren", mem_wren, 1);
      check("wr_rst_write_addr", mem_address, 12);
      apply_reset(2);
      run_clear();

      // Every word reads back as zero.
      wait_disp("post_first", 1, 0, 10);
      for (int k = 2; k <= 32; k++) begin
         wait_disp("post_scan", k % 32, 0, 9);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
